fetch_unit: RTL

Instruction fetch stage directly upstream of the decode stage. Generates the PC and issues requests to instruction memory over a valid/ready request channel with in-order, variable-latency responses. Buffers returned words in a small prefetch FIFO and drives the IF/ID register (instrD, PCD, PCPlus4D) consumed by the main decoder. Handles decode stalls, and redirects from execute on taken branch/jal/jalr, including discard of stale in-flight responses.

---
 rtl/riscv_pkg.sv | 8 +
 rtl/fetch_fifo.sv | 60 ++++++
 rtl/fetch_unit.sv | 118 +++++++++++
 3 files changed

// File: rtl/riscv_pkg.sv
// Shared constants for the fetch front end.
package riscv_pkg;
  localparam int          DEF_XLEN       = 32;
  localparam logic [31:0] DEF_RESET_PC   = 32'h0000_0000;
  localparam int          DEF_FIFO_DEPTH = 2;
  // All-zero word decodes as the control bubble in the main decoder
  localparam logic [31:0] BUBBLE_INSTR   = 32'h0000_0000;
endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO with a clear that wins over push/pop. The head word is
// read combinationally from storage, so a pushed word is visible one edge later.
module fetch_fifo
  import riscv_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         pushData,
  input  logic                     pop,
  input  logic                     clear,
  output logic [WIDTH-1:0]         popData,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wrPtr, rdPtr;
  logic [AW:0]      cnt;
  logic             doPush, doPop;

  assign doPush  = push && !full;
  assign doPop   = pop && !empty;
  assign popData = mem[rdPtr];
  assign full    = (cnt == DEPTH_C);
  assign empty   = (cnt == '0);
  assign count   = cnt;

  // Pointer and occupancy tracking; pointers wrap naturally since DEPTH is a power of 2
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wrPtr <= '0;
      rdPtr <= '0;
      cnt   <= '0;
    end else if (clear) begin
      wrPtr <= '0;
      rdPtr <= '0;
      cnt   <= '0;
    end else begin
      if (doPush) wrPtr <= wrPtr + 1'b1;
      if (doPop)  rdPtr <= rdPtr + 1'b1;
      case ({doPush, doPop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  // Storage needs no reset; occupancy alone says what is valid
  always_ff @(posedge clk) begin
    if (doPush && !clear) mem[wrPtr] <= pushData;
  end
endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: PC generation, credit-limited imem requests, prefetch
// buffering and the IF/ID register, with redirect flush and stale-response drop.
module fetch_unit
  import riscv_pkg::*;
#(
  parameter int              XLEN       = DEF_XLEN,
  parameter logic [XLEN-1:0] RESET_PC   = XLEN'(DEF_RESET_PC),
  parameter int              FIFO_DEPTH = DEF_FIFO_DEPTH
) (
  input  logic            clk,
  input  logic            reset,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [31:0]     imem_rsp_data,
  input  logic            StallD,
  input  logic            PCSrcE,
  input  logic [XLEN-1:0] PCTargetE,
  output logic [31:0]     instrD,
  output logic [XLEN-1:0] PCD,
  output logic [XLEN-1:0] PCPlus4D,
  output logic            validD
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW:0] DEPTH_C = (CW+1)'(FIFO_DEPTH);

  typedef struct packed {
    logic [31:0]     instr;
    logic [XLEN-1:0] pc;
  } fetchEntry_t;

  logic [XLEN-1:0] pcF, rspPc;
  logic [CW-1:0]   outstanding, dropCnt, fifoCount;
  logic [CW:0]     inUse;
  logic            reqEn, accept, rspKeep, pop, fifoFull, fifoEmpty;
  fetchEntry_t     pushEntry, popEntry;

  // Outstanding plus buffered words never exceed the FIFO depth, so a
  // response always has a slot waiting for it.
  assign inUse          = {1'b0, outstanding} + {1'b0, fifoCount};
  assign imem_req_valid = reqEn && !PCSrcE && (inUse < DEPTH_C);
  assign imem_req_addr  = pcF;
  assign accept         = imem_req_valid && imem_req_ready;
  assign rspKeep        = imem_rsp_valid && (dropCnt == '0) && !PCSrcE && !fifoFull;
  assign pop            = !PCSrcE && !StallD && !fifoEmpty;
  assign pushEntry      = '{instr: imem_rsp_data, pc: rspPc};

  fetch_fifo #(
    .WIDTH ($bits(fetchEntry_t)),
    .DEPTH (FIFO_DEPTH)
  ) uFifo (
    .clk      (clk),
    .reset    (reset),
    .push     (rspKeep),
    .pushData (pushEntry),
    .pop      (pop),
    .clear    (PCSrcE),
    .popData  (popEntry),
    .full     (fifoFull),
    .empty    (fifoEmpty),
    .count    (fifoCount)
  );

  // PC, response-PC tag counter, in-flight and drop bookkeeping
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      reqEn       <= 1'b0;
      pcF         <= RESET_PC;
      rspPc       <= RESET_PC;
      outstanding <= '0;
      dropCnt     <= '0;
    end else begin
      reqEn <= 1'b1;
      if (PCSrcE) begin
        pcF   <= PCTargetE;
        rspPc <= PCTargetE;
      end else begin
        if (accept)  pcF   <= pcF + XLEN'(4);
        if (rspKeep) rspPc <= rspPc + XLEN'(4);
      end
      case ({accept, imem_rsp_valid})
        2'b10:   outstanding <= outstanding + 1'b1;
        2'b01:   outstanding <= outstanding - 1'b1;
        default: outstanding <= outstanding;
      endcase
      // On redirect every request still in flight after this edge is stale
      if (PCSrcE)
        dropCnt <= outstanding - CW'(imem_rsp_valid);
      else if (imem_rsp_valid && (dropCnt != '0))
        dropCnt <= dropCnt - 1'b1;
    end
  end

  // IF/ID register: flush beats stall beats pop, otherwise insert a bubble
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      instrD   <= BUBBLE_INSTR;
      PCD      <= '0;
      PCPlus4D <= '0;
      validD   <= 1'b0;
    end else if (PCSrcE) begin
      instrD <= BUBBLE_INSTR;
      validD <= 1'b0;
    end else if (StallD) begin
      instrD <= instrD;
      validD <= validD;
    end else if (!fifoEmpty) begin
      instrD   <= popEntry.instr;
      PCD      <= popEntry.pc;
      PCPlus4D <= popEntry.pc + XLEN'(4);
      validD   <= 1'b1;
    end else begin
      instrD <= BUBBLE_INSTR;
      validD <= 1'b0;
    end
  end
endmodule
